// File: rtl/axi2wb_bridge.sv
// AXI4-Lite slave to Wishbone classic master, one transaction at a time; the cycle starts on the accept edge.
// Response is registered one cycle after ack/err/timeout and held until ready; AXI is stalled while busy.
module axi2wb_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   s_awaddr,
  input  logic                s_awvalid,
  output logic                s_awready,
  input  logic [DATA_W-1:0]   s_wdata,
  input  logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_wvalid,
  output logic                s_wready,
  output logic [1:0]          s_bresp,
  output logic                s_bvalid,
  input  logic                s_bready,
  input  logic [ADDR_W-1:0]   s_araddr,
  input  logic                s_arvalid,
  output logic                s_arready,
  output logic [DATA_W-1:0]   s_rdata,
  output logic [1:0]          s_rresp,
  output logic                s_rvalid,
  input  logic                s_rready,
  output logic [ADDR_W-1:0]   wb_adr_o,
  output logic [DATA_W-1:0]   wb_dat_o,
  input  logic [DATA_W-1:0]   wb_dat_i,
  output logic [DATA_W/8-1:0] wb_sel_o,
  output logic                wb_we_o,
  output logic                wb_cyc_o,
  output logic                wb_stb_o,
  input  logic                wb_ack_i,
  input  logic                wb_err_i
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(TIMEOUT);

  typedef enum logic [2:0] {IDLE, WB_WR, WB_RD, B_RESP, R_RESP} state_t;

  state_t              state_q, state_d;
  logic                aw_held_q, aw_held_d, w_held_q, w_held_d, ar_held_q, ar_held_d;
  logic                last_was_write_q, last_was_write_d;
  logic [ADDR_W-1:0]   aw_addr_q, aw_addr_d, ar_addr_q, ar_addr_d;
  logic [DATA_W-1:0]   w_data_q, w_data_d;
  logic [STRB_W-1:0]   w_strb_q, w_strb_d;
  logic                aw_rdy_q, aw_rdy_d, w_rdy_q, w_rdy_d, ar_rdy_q, ar_rdy_d;
  logic                bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0]          bresp_q, bresp_d, rresp_q, rresp_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [ADDR_W-1:0]   wb_adr_q, wb_adr_d;
  logic [DATA_W-1:0]   wb_dat_q, wb_dat_d;
  logic [STRB_W-1:0]   wb_sel_q, wb_sel_d;
  logic                wb_we_q, wb_we_d, wb_cyc_q, wb_cyc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic aw_hs, w_hs, ar_hs, wr_elig, rd_elig, start_wr, start_rd;
  logic wb_term;
  logic [1:0] wb_resp;

  assign aw_hs   = s_awvalid && aw_rdy_q;
  assign w_hs    = s_wvalid && w_rdy_q;
  assign ar_hs   = s_arvalid && ar_rdy_q;
  assign wr_elig = (aw_held_q || aw_hs) && (w_held_q || w_hs);
  // An AR that loses arbitration to a write stays parked in ar_held_q.
  assign rd_elig = ar_held_q || ar_hs;
  assign start_wr = wr_elig && (!rd_elig || !last_was_write_q);
  assign start_rd = rd_elig && !start_wr;

  assign wb_term = wb_ack_i || wb_err_i || (cnt_q == CNT_W'(TIMEOUT - 1));
  assign wb_resp = wb_err_i ? 2'b10 : (wb_ack_i ? 2'b00 : 2'b11);

  always_comb begin
    state_d          = state_q;
    aw_held_d        = aw_held_q;
    w_held_d         = w_held_q;
    ar_held_d        = ar_held_q;
    last_was_write_d = last_was_write_q;
    aw_addr_d        = aw_addr_q;
    ar_addr_d        = ar_addr_q;
    w_data_d         = w_data_q;
    w_strb_d         = w_strb_q;
    bresp_d          = bresp_q;
    rresp_d          = rresp_q;
    rdata_d          = rdata_q;
    wb_adr_d         = wb_adr_q;
    wb_dat_d         = wb_dat_q;
    wb_sel_d         = wb_sel_q;
    cnt_d            = cnt_q;

    if (aw_hs) begin
      aw_held_d = 1'b1;
      aw_addr_d = s_awaddr;
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      w_data_d = s_wdata;
      w_strb_d = s_wstrb;
    end
    if (ar_hs) begin
      ar_held_d = 1'b1;
      ar_addr_d = s_araddr;
    end

    unique case (state_q)
      IDLE: begin
        if (start_wr) begin
          state_d          = WB_WR;
          last_was_write_d = 1'b1;
          cnt_d            = '0;
          wb_adr_d         = aw_held_q ? aw_addr_q : s_awaddr;
          wb_dat_d         = w_held_q ? w_data_q : s_wdata;
          wb_sel_d         = w_held_q ? w_strb_q : s_wstrb;
        end else if (start_rd) begin
          state_d          = WB_RD;
          last_was_write_d = 1'b0;
          cnt_d            = '0;
          wb_adr_d         = ar_held_q ? ar_addr_q : s_araddr;
          wb_sel_d         = '1;
        end
      end
      WB_WR: begin
        if (wb_term) begin
          state_d = B_RESP;
          bresp_d = wb_resp;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WB_RD: begin
        if (wb_term) begin
          state_d = R_RESP;
          rresp_d = wb_resp;
          rdata_d = (wb_ack_i && !wb_err_i) ? wb_dat_i : '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      B_RESP: begin
        if (s_bready) begin
          state_d   = IDLE;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
        end
      end
      R_RESP: begin
        if (s_rready) begin
          state_d   = IDLE;
          ar_held_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Handshake and cycle outputs are registered from the next-state view.
    aw_rdy_d = (state_d == IDLE) && !aw_held_d;
    w_rdy_d  = (state_d == IDLE) && !w_held_d;
    ar_rdy_d = (state_d == IDLE) && !ar_held_d && !aw_held_d && !w_held_d;
    bvalid_d = (state_d == B_RESP);
    rvalid_d = (state_d == R_RESP);
    wb_cyc_d = (state_d == WB_WR) || (state_d == WB_RD);
    wb_we_d  = (state_d == WB_WR);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      aw_held_q        <= 1'b0;
      w_held_q         <= 1'b0;
      ar_held_q        <= 1'b0;
      last_was_write_q <= 1'b0;
      aw_addr_q        <= '0;
      ar_addr_q        <= '0;
      w_data_q         <= '0;
      w_strb_q         <= '0;
      aw_rdy_q         <= 1'b0;
      w_rdy_q          <= 1'b0;
      ar_rdy_q         <= 1'b0;
      bvalid_q         <= 1'b0;
      rvalid_q         <= 1'b0;
      bresp_q          <= 2'b00;
      rresp_q          <= 2'b00;
      rdata_q          <= '0;
      wb_adr_q         <= '0;
      wb_dat_q         <= '0;
      wb_sel_q         <= '0;
      wb_we_q          <= 1'b0;
      wb_cyc_q         <= 1'b0;
      cnt_q            <= '0;
    end else begin
      state_q          <= state_d;
      aw_held_q        <= aw_held_d;
      w_held_q         <= w_held_d;
      ar_held_q        <= ar_held_d;
      last_was_write_q <= last_was_write_d;
      aw_addr_q        <= aw_addr_d;
      ar_addr_q        <= ar_addr_d;
      w_data_q         <= w_data_d;
      w_strb_q         <= w_strb_d;
      aw_rdy_q         <= aw_rdy_d;
      w_rdy_q          <= w_rdy_d;
      ar_rdy_q         <= ar_rdy_d;
      bvalid_q         <= bvalid_d;
      rvalid_q         <= rvalid_d;
      bresp_q          <= bresp_d;
      rresp_q          <= rresp_d;
      rdata_q          <= rdata_d;
      wb_adr_q         <= wb_adr_d;
      wb_dat_q         <= wb_dat_d;
      wb_sel_q         <= wb_sel_d;
      wb_we_q          <= wb_we_d;
      wb_cyc_q         <= wb_cyc_d;
      cnt_q            <= cnt_d;
    end
  end

  assign s_awready = aw_rdy_q;
  assign s_wready  = w_rdy_q;
  assign s_arready = ar_rdy_q;
  assign s_bvalid  = bvalid_q;
  assign s_bresp   = bresp_q;
  assign s_rvalid  = rvalid_q;
  assign s_rresp   = rresp_q;
  assign s_rdata   = rdata_q;
  assign wb_adr_o  = wb_adr_q;
  assign wb_dat_o  = wb_dat_q;
  assign wb_sel_o  = wb_sel_q;
  assign wb_we_o   = wb_we_q;
  assign wb_cyc_o  = wb_cyc_q;
  assign wb_stb_o  = wb_cyc_q;

endmodule

// File: doc/axi2wb_bridge.md
# axi2wb_bridge

- AXI4-Lite slave to Wishbone B4 classic master bridge.
- It is the reverse-direction counterpart of the block_3 Wishbone-to-AXI path. It accepts single AXI4-Lite read and write transactions and converts each into one Wishbone classic cycle.
- It returns the Wishbone completion as an AXI response.
- It sits between an AXI4-Lite interconnect and a Wishbone peripheral segment. In the block bench it is driven by an axi_master agent and answered by a wb_slave agent.

## Interface
Parameters:
- ADDR_W, 32, address width on both sides.
- DATA_W, 32, data width; must be 32 or 64. Strobe/select width is DATA_W/8.
- TIMEOUT, 256, maximum Wishbone cycles to wait for ack/err; must be ≥2.

Ports:
- clk  in  1  single clock for all logic.
- rst_n  in  1  synchronous, active-low reset.
- s_awaddr  in  ADDR_W  write address.
- s_awvalid / s_awready  in / out  1  AW handshake.
- s_wdata  in  DATA_W  write data.
- s_wstrb  in  DATA_W/8  write byte strobes.
- s_wvalid / s_wready  in / out  1  W handshake.
- s_bresp  out  2  write response.
- s_bvalid / s_bready  out / in  1  B handshake.
- s_araddr  in  ADDR_W  read address.
- s_arvalid / s_arready  in / out  1  AR handshake.
- s_rdata  out  DATA_W  read data.
- s_rresp  out  2  read response.
- s_rvalid / s_rready  out / in  1  R handshake.
- wb_adr_o  out  ADDR_W  Wishbone address.
- wb_dat_o  out  DATA_W  Wishbone write data.
- wb_dat_i  in  DATA_W  Wishbone read data.
- wb_sel_o  out  DATA_W/8  byte selects.
- wb_we_o  out  1  write enable.
- wb_cyc_o  out  1  cycle valid.
- wb_stb_o  out  1  strobe.
- wb_ack_i  in  1  normal termination.
- wb_err_i  in  1  error termination.

## Operation
- One transaction outstanding at a time.
- FSM states: IDLE, WB_WR, WB_RD, B_RESP, R_RESP.
- Holding registers for AW and for W are filled independently:
  - s_awready=1 only in IDLE while AW is not held.
  - s_wready=1 only in IDLE while W is not held.
  - s_arready=1 only in IDLE when neither AW nor W is held and no write is eligible.
- Arbitration in IDLE:
  - A write is eligible when both AW and W are held.
  - A read is eligible on s_arvalid.
  - If both are eligible in the same cycle, priority alternates. A last_was_write flag is reset to 0, so the write wins first.
- IDLE→WB_WR: drive wb_adr_o=awaddr, wb_dat_o=wdata, wb_sel_o=wstrb, wb_we_o=1, wb_cyc_o=wb_stb_o=1.
- IDLE→WB_RD: on AR handshake drive wb_adr_o=araddr, wb_sel_o=all ones, wb_we_o=0, cyc=stb=1.
- WB_WR / WB_RD termination:
  - wb_ack_i → response OKAY (2'b00).
  - wb_err_i → SLVERR (2'b10). err takes precedence if sampled together with ack.
  - Timeout counter reaching TIMEOUT with no ack/err → DECERR (2'b11).
  - On termination, cyc/stb drop and the FSM moves to B_RESP or R_RESP.
  - The timeout counter clears on entry to WB_WR/WB_RD.
- Read data: s_rdata is captured from wb_dat_i on ack. It is 0 on err or timeout.
- B_RESP / R_RESP: hold valid and response stable until ready, then clear the consumed holding registers and return to IDLE.
- Address and data are passed through unchanged; the bridge does no alignment checking.
- ack/err arriving while cyc=0 are ignored.

## Timing
- Reset (rst_n=0 at a clk edge):
  - Values: all ready/valid outputs 0, wb_cyc_o=wb_stb_o=wb_we_o=0, wb_adr_o/wb_dat_o/wb_sel_o=0, s_bresp=s_rresp=0, s_rdata=0.
  - Side effects: holding registers are emptied, the FSM goes to IDLE, and last_was_write is set to 0.
  - Reset mid-cycle drops cyc/stb on the next edge with no AXI response issued.
- Write latency:
  - Last of AW/W handshakes at edge N → cyc/stb high from N+1.
  - ack sampled at edge K → cyc/stb low and s_bvalid high from K+1.
  - Minimum handshake-to-bvalid latency is 2 cycles.
- Read latency: AR handshake at edge N → cyc from N+1; ack at K → s_rvalid at K+1 with registered data.
- Timeout: cyc high for TIMEOUT consecutive cycles without ack/err → DECERR response on the following cycle.
- Back-to-back: bready=1 at the B_RESP entry edge → IDLE next cycle, and the next Wishbone cycle starts one cycle after the next acceptance.
- AW and W may arrive in either order or in the same cycle; each handshake occurs at most once per transaction.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Write 0x1000←0xDEADBEEF, wstrb=0xF, AW and W in the same cycle, ack after 3 cycles → wb_sel_o=0xF, we=1, cyc held 3 cycles, bresp=00 one cycle after ack.
- W arrives 4 cycles before AW (wstrb=0x3) → no Wishbone cycle until AW accepted; wb_sel_o=0x3; cyc starts the cycle after AW.
- Read 0x2004, slave returns 0x12345678 with err=0; rready held low 5 cycles → rvalid, rdata=0x12345678, rresp=00 stable until rready.
- wb_err_i on a read → rresp=10, rdata=0. With TIMEOUT=8 and slave silent on a write → cyc low after 8 cycles, bresp=11.
- AR and AW+W pending simultaneously, twice in a row → order is write, read, write, read; the Wishbone cycles never overlap.
- rst_n asserted during WB_RD → cyc/stb 0 on the next edge, no rvalid, and a following write completes normally.
